// File: rtl/fetch_redirect_if.sv
// Branch-resolution and fetch-status bundle between EX/hazard logic and the IF-stage PC controller.
// PCSrc/calcBranch carry no ready: PCSrc is valid every cycle, and the PC controller alone decides
// whether to accept it (only in RUN); calcBranch is meaningful only in a cycle where PCSrc is accepted.
interface fetch_redirect_if;
    logic        PCSrc;
    logic [63:0] calcBranch;
    logic        stall;
    logic [63:0] instAddr;
    logic        squash_ID;
    logic        squash_EX;
    logic [31:0] redirectCount;
    logic        misalignFault;
    logic        fsm_state;

    modport master (
        output PCSrc, calcBranch, stall,
        input  instAddr, squash_ID, squash_EX, redirectCount, misalignFault, fsm_state
    );

    modport slave (
        input  PCSrc, calcBranch, stall,
        output instAddr, squash_ID, squash_EX, redirectCount, misalignFault, fsm_state
    );
endinterface

// File: rtl/fetch_redirect.sv
// IF-stage PC register with redirect, stall and two-bubble squash control.
// fsm_state exposes the controller state (0 = RUN, 1 = SQUASH).
module fetch_redirect #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic             clk,
    input logic             reset,
    fetch_redirect_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        fault_q;
    logic        fault_d;
    logic        accept;

    // A branch raised during SQUASH belongs to a squashed instruction and is never accepted.
    assign accept = bus.PCSrc && (state_q == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = accept ? SQUASH : RUN;
            SQUASH:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Redirect beats stall; stall is meaningless in SQUASH since it came from a squashed instruction.
    always_comb begin
        pc_d    = pc_q + 64'd4;
        count_d = count_q;
        fault_d = fault_q;
        if (accept) begin
            pc_d    = {bus.calcBranch[63:2], 2'b00};
            count_d = count_q + 32'd1;
            fault_d = fault_q | (bus.calcBranch[1:0] != 2'b00);
        end else if ((state_q == RUN) && bus.stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign bus.instAddr      = pc_q;
    assign bus.squash_ID     = (state_q == SQUASH);
    assign bus.squash_EX     = (state_q == SQUASH);
    assign bus.redirectCount = count_q;
    assign bus.misalignFault = fault_q;
    assign bus.fsm_state     = state_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed vector table, counter-wrap sequence, then random traffic vs a model.
module tb_fetch_redirect;
    localparam logic [63:0] RST_PC = 64'h100;

    logic clk;
    logic reset;
    fetch_redirect_if bus ();

    fetch_redirect #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the PC, whether the next cycle is a bubble-producing one, counter, fault.
    logic [63:0] m_pc;
    logic        m_bubble;
    logic [31:0] m_cnt;
    logic        m_fault;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        r;
        logic        p;
        logic [63:0] t;
        logic        s;
        logic [63:0] pc;
        logic        sq;
        logic [31:0] cnt;
        logic        f;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic p, input logic [63:0] t, input logic s);
        if (r) begin
            m_pc = RST_PC; m_bubble = 1'b0; m_cnt = 0; m_fault = 1'b0;
        end else if (m_bubble) begin
            m_pc = m_pc + 64'd4; m_bubble = 1'b0;
        end else if (p) begin
            m_pc     = t - (t % 64'd4);
            m_bubble = 1'b1;
            m_cnt    = m_cnt + 1;
            m_fault  = m_fault | ((t % 64'd4) != 0);
        end else if (!s) begin
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic apply(input logic r, input logic p, input logic [63:0] t, input logic s);
        reset = r; bus.PCSrc = p; bus.calcBranch = t; bus.stall = s;
        model_step(r, p, t, s);
        exp_q.push_back(m_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [63:0] e;
        e = exp_q.pop_front();
        check({tag, " instAddr"}, bus.instAddr, e);
        check({tag, " squash_ID"}, 64'(bus.squash_ID), 64'(m_bubble));
        check({tag, " squash_EX"}, 64'(bus.squash_EX), 64'(m_bubble));
        check({tag, " redirectCount"}, 64'(bus.redirectCount), 64'(m_cnt));
        check({tag, " misalignFault"}, 64'(bus.misalignFault), 64'(m_fault));
        check({tag, " fsm_state"}, 64'(bus.fsm_state), 64'(m_bubble));
    endtask

    task automatic add(input logic r, input logic p, input logic [63:0] t, input logic s,
                       input logic [63:0] pc, input logic sq, input logic [31:0] cnt, input logic f);
        vec_t v;
        v.r = r; v.p = p; v.t = t; v.s = s; v.pc = pc; v.sq = sq; v.cnt = cnt; v.f = f;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; bus.PCSrc = 1'b0; bus.calcBranch = '0; bus.stall = 1'b0;

        //    r  p  target                  s  instAddr                sq cnt f
        add(1, 0, 64'h0,                  0, 64'h100,                0, 0, 0);
        add(1, 0, 64'h0,                  0, 64'h100,                0, 0, 0);
        add(0, 0, 64'h0,                  0, 64'h104,                0, 0, 0);
        add(0, 0, 64'h0,                  0, 64'h108,                0, 0, 0);
        add(0, 1, 64'h40,                 0, 64'h40,                 1, 1, 0);
        add(0, 0, 64'h0,                  0, 64'h44,                 0, 1, 0);
        add(0, 0, 64'h0,                  0, 64'h48,                 0, 1, 0);
        add(0, 1, 64'h80,                 0, 64'h80,                 1, 2, 0);
        add(0, 1, 64'h200,                0, 64'h84,                 0, 2, 0);
        add(0, 0, 64'h0,                  0, 64'h88,                 0, 2, 0);
        add(0, 1, 64'h1c,                 0, 64'h1c,                 1, 3, 0);
        add(0, 0, 64'h0,                  0, 64'h20,                 0, 3, 0);
        add(0, 0, 64'h0,                  1, 64'h20,                 0, 3, 0);
        add(0, 0, 64'h0,                  1, 64'h20,                 0, 3, 0);
        add(0, 0, 64'h0,                  1, 64'h20,                 0, 3, 0);
        add(0, 0, 64'h0,                  0, 64'h24,                 0, 3, 0);
        add(0, 1, 64'h300,                1, 64'h300,                1, 4, 0);
        add(0, 0, 64'h0,                  1, 64'h304,                0, 4, 0);
        add(0, 0, 64'h0,                  1, 64'h304,                0, 4, 0);
        add(0, 0, 64'h0,                  0, 64'h308,                0, 4, 0);
        add(0, 1, 64'h1002,               0, 64'h1000,               1, 5, 1);
        add(0, 0, 64'h0,                  0, 64'h1004,               0, 5, 1);
        add(0, 0, 64'h0,                  0, 64'h1008,               0, 5, 1);
        add(0, 1, 64'h2000,               0, 64'h2000,               1, 6, 1);
        add(0, 0, 64'h0,                  0, 64'h2004,               0, 6, 1);
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 7, 1);
        add(0, 0, 64'h0,                  0, 64'h0,                  0, 7, 1);
        add(0, 0, 64'h0,                  0, 64'h4,                  0, 7, 1);
        add(0, 1, 64'h500,                0, 64'h500,                1, 8, 1);
        add(1, 1, 64'h600,                1, 64'h100,                0, 0, 0);
        add(0, 0, 64'h0,                  0, 64'h104,                0, 0, 0);
        add(0, 1, 64'h3C,                 0, 64'h3C,                 1, 1, 0);
        add(0, 0, 64'h0,                  0, 64'h40,                 0, 1, 0);
        add(0, 1, 64'h7000,               0, 64'h7000,               1, 2, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].p, vecs[i].t, vecs[i].s);
            void'(exp_q.pop_front());
            check($sformatf("vec%0d instAddr", i), bus.instAddr, vecs[i].pc);
            check($sformatf("vec%0d squash_ID", i), 64'(bus.squash_ID), 64'(vecs[i].sq));
            check($sformatf("vec%0d squash_EX", i), 64'(bus.squash_EX), 64'(vecs[i].sq));
            check($sformatf("vec%0d redirectCount", i), 64'(bus.redirectCount), 64'(vecs[i].cnt));
            check($sformatf("vec%0d misalignFault", i), 64'(bus.misalignFault), 64'(vecs[i].f));
        end

        // Counter wrap: preload all-ones, then two redirects must read 0 and 1.
        apply(0, 0, 64'h0, 0);
        check_model("pre_wrap");
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_cnt = 32'hFFFF_FFFF;
        apply(0, 1, 64'h800, 0);
        check_model("wrap0");
        check("wrap0 literal", 64'(bus.redirectCount), 64'h0);
        apply(0, 0, 64'h0, 0);
        check_model("wrap_sq");
        apply(0, 1, 64'h900, 1);
        check_model("wrap1");
        check("wrap1 literal", 64'(bus.redirectCount), 64'h1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic        r;
            logic        p;
            logic        s;
            logic [63:0] t;
            r = ($urandom_range(0, 39) == 0);
            p = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
            apply(r, p, t, s);
            check_model($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
